// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: holds the fetch PC, issues imem reads and buffers words for decode.
// Build option IFU_PREFETCH_EN selects a 2-entry prefetch FIFO; the default is a single-entry buffer.
module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        halted
);

`ifdef IFU_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {S_FETCH, S_STOP, S_HALTED} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_instr_q [2];
  logic [31:0]      buf_instr_d [2];
  logic [31:0]      buf_pc_q [2];
  logic [31:0]      buf_pc_d [2];
  logic [31:0]      buf_npc_q [2];
  logic [31:0]      buf_npc_d [2];

  logic pop, space, fetch_en, capture, is_halt;

  // With a single entry the pointers never move, so the upper slot stays idle.
  function automatic logic ptr_inc(input logic p);
    return (DEPTH > 1) & ~p;
  endfunction

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  assign space       = (count_q != CNT_W'(DEPTH)) | pop;
  assign fetch_en    = (state_q == S_FETCH) & space;
  assign capture     = ihit & fetch_en & ~redirect;
  assign is_halt     = (imemload[31:26] == HALT_OP);

  assign imemREN   = fetch_en;
  assign imemaddr  = pc_q;
  assign instr_out = buf_instr_q[rd_ptr_q];
  assign pc_out    = buf_pc_q[rd_ptr_q];
  assign npc_out   = buf_npc_q[rd_ptr_q];
  assign halted    = (state_q == S_HALTED);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_npc_d   = buf_npc_q;

    // Redirect wins over capture and pop; once HALTED it is ignored.
    if (redirect && state_q != S_HALTED) begin
      state_d  = S_FETCH;
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        if (state_q == S_STOP && count_q == 2'd1) state_d = S_HALTED;
      end
      if (capture) begin
        buf_instr_d[wr_ptr_q] = imemload;
        buf_pc_d[wr_ptr_q]    = pc_q;
        buf_npc_d[wr_ptr_q]   = pc_q + 32'd4;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
        if (is_halt) state_d = S_STOP;
        else         pc_d    = pc_q + 32'd4;
      end
      count_d = count_q + {1'b0, capture} - {1'b0, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_INIT & 32'hFFFF_FFFC;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
        buf_npc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_npc_q   <= buf_npc_d;
    end
  end

endmodule
